memory_responder: RTL and testbench
===================================

Name: memory_responder

Overview:
- Memory-side responder for the core's data path memory interface.
- Serves instruction fetches, loads and stores from a word-addressed RAM with bit-masked writes.
- Also decodes a small MMIO window: cycle counter, tohost halt register, and a console byte FIFO drained by a valid/ready handshake.
- Sits at top level between the core's data path and the test harness/peripherals.

Parameters:
MEMORY_WORDS, 4096, number of 32-bit RAM words; RAM occupies byte addresses 0 .. 4*MEMORY_WORDS-1
INIT_FILE, "", hex image loaded into RAM at elaboration; empty string means RAM contents unspecified
MMIO_BASE, 32'h1000_0000, base byte address of the MMIO window
CONSOLE_DEPTH, 4, console FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
read_memory_address  input  32  byte address of read; bits [1:0] ignored
read_memory_data  output  32  word read from read_memory_address
write_memory_address  input  32  byte address of write; bits [1:0] ignored
write_memory_data  input  32  write data, already lane-aligned
write_memory_mask  input  32  bit mask; a write occurs only when nonzero
console_data  output  8  byte at FIFO head
console_valid  output  1  FIFO non-empty
console_ready  input  1  consumer accepts console_data
halted  output  1  sticky halt flag
exit_code  output  31  value written with the halt

Behaviour:
- Word index = address[31:2]. Region decode is identical for the read and write ports:
  - RAM: byte address < 4*MEMORY_WORDS.
  - MMIO: MMIO_BASE .. MMIO_BASE+0x13.
  - Anything else: unmapped; reads return 0, writes are ignored.
- Reads are combinational, with zero latency and no side effects. The core holds the address for as many cycles as it needs.
- RAM write: on the edge with mask != 0, mem[w] <= (mem[w] & ~mask) | (data & mask).
- Read-during-write to the same word returns the old word until the edge and the new word after it.
- RAM is not cleared by reset.
- MMIO map (offsets from MMIO_BASE):
  - 0x0 / 0x4: cycle counter, low / high word. 64-bit, reset to 0, +1 per edge while !halted. Read-only; writes ignored.
  - 0x8: tohost. Reads {exit_code, halted}.
    - A write with mask[0]=1 and data[0]=1 while !halted sets halted=1 and exit_code=data[31:1].
    - Writes while halted are ignored. halted clears only on reset.
  - 0xC: console. A write with mask[7:0] != 0 pushes data[7:0]. Reads return 0.
  - 0x10: status. Reads {23'b0, overflow, count zero-extended to 8 bits}.
    - A write with mask[8]=1 and data[8]=1 clears overflow (write-1-to-clear).
- Console FIFO:
  - console_valid = (count != 0). console_data = head entry, or 8'h00 when empty.
  - Pop on an edge with console_valid && console_ready.
  - Push and pop on the same edge, including when full: both happen and count is unchanged.
  - Push when full without a pop: byte dropped and sticky overflow set.
  - Pointers wrap modulo CONSOLE_DEPTH.
  - console_data must not change while valid && !ready.
- Reset (reset=0, asynchronous) forces:
  - count=0, pointers=0, overflow=0, halted=0, exit_code=0, cycle counter=0.
  - console_valid=0 and console_data=0 immediately, without waiting for a clock.
- A store arriving mid-handshake on the console does not disturb the head byte.
- Reset asserted mid-handshake drops all queued bytes.

Test Plan:
- RAM byte-masked write: write 32'hDEADBEEF with mask FFFFFFFF to 0x100, then 32'h0000AA00 with mask 0000FF00 to 0x101 -> reading 0x100 returns 32'hDEADAAEF. Write to 0x0000_8000 (unmapped) -> read returns 0.
- Console: ready=0, push 'A','B','C','D','E' -> count=4, 'E' dropped, status reads 0x104. Write 0x100 to status -> reads 0x004. Raise ready -> 'A','B','C','D' on four consecutive edges, then valid=0.
- Full FIFO with ready=1 and a simultaneous push of 'Z' -> count stays 4; 'Z' appears after the original four.
- Cycle counter: after reset release plus N edges, 0x0 reads N. Writes to 0x0 have no effect. Preload-free check via 2^32+3 edges in a fast sim -> 0x4 reads 1, 0x0 reads 3.
- tohost: write 32'h0000_0055 -> halted=1, exit_code=42, counter frozen. A second write of 32'h3 -> exit_code stays 42.
- Async reset pulsed mid-cycle with FIFO holding 2 bytes -> console_valid=0 and halted=0 before the next edge; RAM contents preserved.

Source files
------------

// File: rtl/memory_responder_if.sv
// Core-side memory bus: combinational read port plus a bit-masked write port.
interface memory_responder_if;
    logic [31:0] read_memory_address;
    logic [31:0] read_memory_data;
    logic [31:0] write_memory_address;
    logic [31:0] write_memory_data;
    logic [31:0] write_memory_mask;

    modport master (
        output read_memory_address,
        output write_memory_address,
        output write_memory_data,
        output write_memory_mask,
        input  read_memory_data
    );

    modport slave (
        input  read_memory_address,
        input  write_memory_address,
        input  write_memory_data,
        input  write_memory_mask,
        output read_memory_data
    );
endinterface

// File: rtl/memory_responder.sv
// Word-addressed RAM with bit-masked writes, plus an MMIO window holding a cycle counter,
// a tohost halt register and a console byte FIFO drained over valid/ready.
module memory_responder #(
    parameter int unsigned MEMORY_WORDS  = 4096,
    parameter string       INIT_FILE     = "",
    parameter logic [31:0] MMIO_BASE     = 32'h1000_0000,
    parameter int unsigned CONSOLE_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    memory_responder_if.slave    bus,
    output logic [7:0]           console_data,
    output logic                 console_valid,
    input  logic                 console_ready,
    output logic                 halted,
    output logic [30:0]          exit_code
);

    localparam int unsigned AddrWidth = $clog2(MEMORY_WORDS);
    localparam int unsigned PtrWidth  = $clog2(CONSOLE_DEPTH);
    localparam int unsigned CntWidth  = PtrWidth + 1;
    localparam logic [32:0] RamBytes  = 33'(MEMORY_WORDS) << 2;
    localparam logic [29:0] MmioWord  = MMIO_BASE[31:2];

    typedef enum logic [1:0] {RegNone, RegRam, RegMmio} region_e;

    // RAM wins if the MMIO window is ever configured to overlap it.
    function automatic region_e decode(input logic [31:0] addr);
        logic [29:0] off;
        off = addr[31:2] - MmioWord;
        if ({1'b0, addr} < RamBytes) return RegRam;
        if (off < 30'd5)             return RegMmio;
        return RegNone;
    endfunction

    logic [31:0]          mem [MEMORY_WORDS];
    logic [7:0]           fifo_q [CONSOLE_DEPTH];
    logic [63:0]          cycle_q;
    logic                 halted_q;
    logic [30:0]          exit_code_q;
    logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]  count_q;
    logic                 overflow_q;

    region_e              rd_region, wr_region;
    logic [2:0]           rd_off, wr_off;
    logic [AddrWidth-1:0] rd_idx, wr_idx;
    logic                 ram_we, mmio_we, tohost_set, push, push_acc, pop, full, ovf_clr;

    assign rd_region = decode(bus.read_memory_address);
    assign wr_region = decode(bus.write_memory_address);
    assign rd_off    = 3'(bus.read_memory_address[31:2] - MmioWord);
    assign wr_off    = 3'(bus.write_memory_address[31:2] - MmioWord);
    assign rd_idx    = bus.read_memory_address[AddrWidth+1:2];
    assign wr_idx    = bus.write_memory_address[AddrWidth+1:2];

    assign ram_we     = (wr_region == RegRam) && (|bus.write_memory_mask);
    assign mmio_we    = (wr_region == RegMmio) && (|bus.write_memory_mask);
    assign tohost_set = mmio_we && (wr_off == 3'd2) && bus.write_memory_mask[0] &&
                        bus.write_memory_data[0] && !halted_q;
    assign push       = mmio_we && (wr_off == 3'd3) && (|bus.write_memory_mask[7:0]);
    assign ovf_clr    = mmio_we && (wr_off == 3'd4) && bus.write_memory_mask[8] &&
                        bus.write_memory_data[8];

    assign console_valid = (count_q != '0);
    assign console_data  = console_valid ? fifo_q[rd_ptr_q] : 8'h00;
    assign pop           = console_valid && console_ready;
    assign full          = (count_q == CntWidth'(CONSOLE_DEPTH));
    // When full, a same-edge pop frees the head slot that the push lands in.
    assign push_acc      = push && (!full || pop);

    assign halted    = halted_q;
    assign exit_code = exit_code_q;

    always_comb begin
        bus.read_memory_data = '0;
        case (rd_region)
            RegRam:  bus.read_memory_data = mem[rd_idx];
            RegMmio: begin
                case (rd_off)
                    3'd0:    bus.read_memory_data = cycle_q[31:0];
                    3'd1:    bus.read_memory_data = cycle_q[63:32];
                    3'd2:    bus.read_memory_data = {exit_code_q, halted_q};
                    3'd4:    bus.read_memory_data = {23'b0, overflow_q, 8'(count_q)};
                    default: bus.read_memory_data = '0;
                endcase
            end
            default: bus.read_memory_data = '0;
        endcase
    end

    // RAM and FIFO storage are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_idx] <= (mem[wr_idx] & ~bus.write_memory_mask) |
                           (bus.write_memory_data & bus.write_memory_mask);
        end
        if (push_acc) fifo_q[wr_ptr_q] <= bus.write_memory_data[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q     <= '0;
            halted_q    <= 1'b0;
            exit_code_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (!halted_q) cycle_q <= cycle_q + 64'd1;
            if (tohost_set) begin
                halted_q    <= 1'b1;
                exit_code_q <= bus.write_memory_data[31:1];
            end
            if (push_acc) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            if (pop)      rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            case ({push_acc, pop})
                2'b10:   count_q <= count_q + CntWidth'(1);
                2'b01:   count_q <= count_q - CntWidth'(1);
                default: count_q <= count_q;
            endcase
            if (push && full && !pop) overflow_q <= 1'b1;
            else if (ovf_clr)         overflow_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: console bytes are queued on push and checked on pop.
module tb_memory_responder;

    localparam logic [31:0] Mmio = 32'h1000_0000;

    logic        clk;
    logic        reset;
    logic [7:0]  console_data;
    logic        console_valid;
    logic        console_ready;
    logic        halted;
    logic [30:0] exit_code;

    memory_responder_if bus ();

    memory_responder dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .console_data  (console_data),
        .console_valid (console_valid),
        .console_ready (console_ready),
        .halted        (halted),
        .exit_code     (exit_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [7:0]  sb [$];
    logic [63:0] model_cyc;
    logic        model_halt = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference cycle counter: counts edges out of reset until the bench issues the halt.
    always @(posedge clk or negedge reset) begin
        if (!reset)           model_cyc <= '0;
        else if (!model_halt) model_cyc <= model_cyc + 64'd1;
    end

    // Inputs only change just after a rising edge, so the negedge view holds through the next pop.
    always @(negedge clk) begin
        if (reset && console_valid && console_ready) begin
            if (sb.size() == 0) check("pop_extra", 32'(sb.size()), 32'd1);
            else                check("pop_byte", {24'b0, console_data}, {24'b0, sb.pop_front()});
        end
    end

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.read_memory_address = a;
        #1;
        d = bus.read_memory_data;
    endtask

    task automatic expect_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        bus.write_memory_address = a;
        bus.write_memory_data    = d;
        bus.write_memory_mask    = m;
        sync();
        bus.write_memory_mask    = '0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit kept);
        if (kept) sb.push_back(b);
        wr(Mmio + 32'hC, {24'h0, b}, 32'h0000_00FF);
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b0;
        console_ready = 1'b0;
        bus.read_memory_address  = '0;
        bus.write_memory_address = '0;
        bus.write_memory_data    = '0;
        bus.write_memory_mask    = '0;
        repeat (2) sync();

        check("rst_valid", {31'b0, console_valid}, 32'd0);
        check("rst_data", {24'b0, console_data}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        expect_rd("rst_cyc_lo", Mmio, 32'd0);
        expect_rd("rst_status", Mmio + 32'h10, 32'd0);

        sync();
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        expect_rd("cyc_lo_10", Mmio, 32'd10);
        expect_rd("cyc_hi", Mmio + 32'h4, 32'd0);
        sync();
        wr(Mmio, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_rd("cyc_after_wr", Mmio, model_cyc[31:0]);
        expect_rd("cyc_hi_after_wr", Mmio + 32'h4, 32'd0);
        sync();

        wr(32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        wr(32'h101, 32'h0000_AA00, 32'h0000_FF00);
        expect_rd("ram_masked", 32'h100, 32'hDEAD_AAEF);
        expect_rd("ram_unmapped_before", 32'h8000, 32'd0);
        sync();
        wr(32'h8000, 32'h1234_5678, 32'hFFFF_FFFF);
        expect_rd("ram_unmapped", 32'h8000, 32'd0);
        sync();
        wr(32'h200, 32'h1111_1111, 32'hFFFF_FFFF);
        bus.write_memory_address = 32'h200;
        bus.write_memory_data    = 32'h2222_2222;
        bus.write_memory_mask    = 32'hFFFF_FFFF;
        expect_rd("rdw_old", 32'h200, 32'h1111_1111);
        sync();
        bus.write_memory_mask = '0;
        expect_rd("rdw_new", 32'h200, 32'h2222_2222);
        sync();

        push_byte(8'h41, 1'b1);
        check("con_valid", {31'b0, console_valid}, 32'd1);
        check("con_head_a", {24'b0, console_data}, 32'h41);
        push_byte(8'h42, 1'b1);
        push_byte(8'h43, 1'b1);
        push_byte(8'h44, 1'b1);
        push_byte(8'h45, 1'b0);
        check("con_head_stable", {24'b0, console_data}, 32'h41);
        expect_rd("status_ovf", Mmio + 32'h10, 32'h104);
        expect_rd("console_rd0", Mmio + 32'hC, 32'd0);
        sync();
        wr(Mmio + 32'h10, 32'h100, 32'h100);
        expect_rd("status_clr", Mmio + 32'h10, 32'h004);
        sync();
        console_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        console_ready = 1'b0;
        check("drain_valid", {31'b0, console_valid}, 32'd0);
        check("drain_data", {24'b0, console_data}, 32'd0);
        check("drain_sb", 32'(sb.size()), 32'd0);

        push_byte(8'h61, 1'b1);
        push_byte(8'h62, 1'b1);
        push_byte(8'h63, 1'b1);
        push_byte(8'h64, 1'b1);
        console_ready = 1'b1;
        push_byte(8'h5A, 1'b1);
        expect_rd("full_pushpop_cnt", Mmio + 32'h10, 32'h004);
        repeat (4) @(posedge clk);
        #1;
        console_ready = 1'b0;
        check("z_valid", {31'b0, console_valid}, 32'd0);
        check("z_sb", 32'(sb.size()), 32'd0);

        sync();
        wr(Mmio + 32'h8, 32'h0000_0055, 32'hFFFF_FFFF);
        model_halt = 1'b1;
        check("halt_set", {31'b0, halted}, 32'd1);
        check("exit_code", {1'b0, exit_code}, 32'd42);
        expect_rd("tohost_rd", Mmio + 32'h8, 32'h55);
        repeat (5) @(posedge clk);
        #1;
        expect_rd("cyc_frozen", Mmio, model_cyc[31:0]);
        sync();
        wr(Mmio + 32'h8, 32'h3, 32'hFFFF_FFFF);
        check("exit_sticky", {1'b0, exit_code}, 32'd42);
        check("halt_sticky", {31'b0, halted}, 32'd1);

        push_byte(8'h78, 1'b1);
        push_byte(8'h79, 1'b1);
        check("pre_rst_valid", {31'b0, console_valid}, 32'd1);
        #2;
        reset = 1'b0;
        sb.delete();
        model_halt = 1'b0;
        #1;
        check("arst_valid", {31'b0, console_valid}, 32'd0);
        check("arst_data", {24'b0, console_data}, 32'd0);
        check("arst_halted", {31'b0, halted}, 32'd0);
        check("arst_exit", {1'b0, exit_code}, 32'd0);
        sync();
        reset = 1'b1;
        expect_rd("ram_kept", 32'h100, 32'hDEAD_AAEF);
        expect_rd("arst_status", Mmio + 32'h10, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        expect_rd("cyc_after_rst", Mmio, model_cyc[31:0]);
        check("final_sb", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
